dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 33 +++
 rtl/dmem_rsp_reg.sv | 57 +++++
 rtl/dmem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//     - default DEPTH / STARVE_MAX / LOCK_MAX values
//     - arbiter FSM state enum
//     - port indices used by the per-port response generate loop
//     - address range helper
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned DEFAULT_DEPTH      = 1024;
    localparam int unsigned DEFAULT_STARVE_MAX = 4;
    localparam int unsigned DEFAULT_LOCK_MAX   = 8;

    // Response-path port indices (pipeline M port, debug/DMA D port)
    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned PORT_M    = 0;
    localparam int unsigned PORT_D    = 1;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,  // pipeline has priority
        ST_FORCE_D = 2'd1,  // D starved long enough: one D transfer forced
        ST_LOCK_D  = 2'd2   // D holds a locked burst
    } arb_state_e;

    // Word address falls inside the data memory.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                           input int unsigned       depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// -----------------------------------------------------------------------------
// dmem_rsp_reg
//   Registered read-response path for one arbiter port.
//   A granted read captures the memory read data at the grant edge and raises
//   rvalid for exactly one cycle; rdata then holds until the next granted read.
//   A granted out-of-range access returns zero data (for reads) and pulses err
//   for one cycle.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   fire       in   this port is granted (transfer) this cycle
//   we         in   transfer is a write
//   in_range   in   transfer address is inside the memory
//   mem_rdata  in   combinational memory read data for the granted address
//   rvalid     out  read response valid (one cycle after a granted read)
//   rdata      out  read response data, held between responses
//   err        out  one-cycle pulse after a granted out-of-range access
// -----------------------------------------------------------------------------
module dmem_rsp_reg
    import dmem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  logic              we,
    input  logic              in_range,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            rvalid_reg <= fire & ~we;
            err_reg    <= fire & ~in_range;
            if (fire && !we) begin
                // Out-of-range reads complete normally but return zero.
                rdata_reg <= in_range ? mem_rdata : '0;
            end
        end
    end

    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;
    assign err    = err_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Arbitrates a single-port data memory between the pipeline memory stage
//   (M port) and a debug/DMA master (D port).
//
//   Grants are combinational and mutually exclusive. The pipeline normally
//   wins; the D port is protected against starvation by a counter that forces
//   one D transfer after STARVE_MAX consecutive denied request cycles, and it
//   may hold the memory for a locked burst of at most LOCK_MAX grants (the
//   grant that starts the burst counts as the first).
//
// Parameters
//   DEPTH       memory depth in 32-bit words; addr >= DEPTH is out of range
//   STARVE_MAX  denied D request cycles that force a D grant
//   LOCK_MAX    maximum consecutive locked D grants
//
// Ports
//   clk, rst                       clock, asynchronous active-low reset
//   m_req/m_we/m_addr/m_wdata      pipeline request
//   m_gnt, stall_m                 pipeline grant and hazard stall
//   m_rvalid/m_rdata               pipeline read response (1-cycle latency)
//   d_req/d_we/d_lock/d_addr/d_wdata  debug/DMA request with burst lock
//   d_gnt, d_rvalid/d_rdata        debug/DMA grant and read response
//   mem_we/mem_addr/mem_wdata      memory command (addr/wdata hold when idle)
//   mem_rdata                      combinational memory read data
//   err                            one-cycle pulse after an out-of-range access
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned STARVE_MAX = DEFAULT_STARVE_MAX,
    parameter int unsigned LOCK_MAX   = DEFAULT_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [DATA_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              stall_m,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);
    // With LOCK_MAX of 1 the entry grant already exhausts the burst, so the
    // lock state is never entered.
    localparam bit LOCK_EN = (LOCK_MAX > 1);

    arb_state_e state_reg, state_next;
    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
    logic [LW-1:0] lock_cnt_reg, lock_cnt_next;

    logic m_gnt_c, d_gnt_c;
    logic m_in_range, d_in_range;
    logic mem_we_c;
    logic [DATA_W-1:0] mem_addr_c, mem_wdata_c;
    logic [DATA_W-1:0] mem_addr_hold_reg, mem_wdata_hold_reg;

    assign m_in_range = addr_in_range(m_addr, DEPTH);
    assign d_in_range = addr_in_range(d_addr, DEPTH);

    // -------------------------------------------------------------------------
    // FSM state and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_NORMAL;
            starve_cnt_reg <= '0;
            lock_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        lock_cnt_next   = '0;
        starve_cnt_next = '0;

        if (d_req && !d_gnt_c) begin
            if (starve_cnt_reg >= SW'(STARVE_MAX)) begin
                starve_cnt_next = starve_cnt_reg;
            end else begin
                starve_cnt_next = starve_cnt_reg + 1'b1;
            end
        end

        case (state_reg)
            ST_NORMAL: begin
                if (d_gnt_c && d_lock && LOCK_EN) begin
                    state_next    = ST_LOCK_D;
                    lock_cnt_next = LW'(1);
                end else if (starve_cnt_next == SW'(STARVE_MAX)) begin
                    // Transition on the updated count so the forced grant
                    // lands in the very next cycle.
                    state_next = ST_FORCE_D;
                end
            end
            ST_FORCE_D: begin
                // Either the forced transfer happens this cycle or the
                // requester went away; both end the forced window.
                if (d_gnt_c && d_lock && LOCK_EN) begin
                    state_next    = ST_LOCK_D;
                    lock_cnt_next = LW'(1);
                end else begin
                    state_next = ST_NORMAL;
                end
            end
            ST_LOCK_D: begin
                if (!d_req || !d_lock || lock_cnt_reg >= LW'(LOCK_MAX - 1)) begin
                    state_next = ST_NORMAL;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_NORMAL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: grants and memory command
    // -------------------------------------------------------------------------
    always_comb begin
        m_gnt_c     = 1'b0;
        d_gnt_c     = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = mem_addr_hold_reg;
        mem_wdata_c = mem_wdata_hold_reg;

        // Grants are held off for the whole time reset is asserted.
        if (rst) begin
            case (state_reg)
                ST_NORMAL: begin
                    m_gnt_c = m_req;
                    d_gnt_c = d_req & ~m_req;
                end
                ST_FORCE_D, ST_LOCK_D: begin
                    d_gnt_c = d_req;
                end
                default: begin
                    m_gnt_c = 1'b0;
                    d_gnt_c = 1'b0;
                end
            endcase
        end

        if (m_gnt_c) begin
            mem_addr_c  = m_addr;
            mem_wdata_c = m_wdata;
            mem_we_c    = m_we & m_in_range;
        end else if (d_gnt_c) begin
            mem_addr_c  = d_addr;
            mem_wdata_c = d_wdata;
            mem_we_c    = d_we & d_in_range;
        end
    end

    // Last driven memory address/data, presented while neither port is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_hold_reg  <= '0;
            mem_wdata_hold_reg <= '0;
        end else if (m_gnt_c || d_gnt_c) begin
            mem_addr_hold_reg  <= mem_addr_c;
            mem_wdata_hold_reg <= mem_wdata_c;
        end
    end

    assign m_gnt     = m_gnt_c;
    assign d_gnt     = d_gnt_c;
    assign stall_m   = m_req & ~m_gnt_c;
    assign mem_we    = mem_we_c;
    assign mem_addr  = mem_addr_c;
    assign mem_wdata = mem_wdata_c;

    // -------------------------------------------------------------------------
    // Per-port read response registers
    // -------------------------------------------------------------------------
    logic [NUM_PORTS-1:0] port_fire;
    logic [NUM_PORTS-1:0] port_we;
    logic [NUM_PORTS-1:0] port_in_range;
    logic [NUM_PORTS-1:0] port_rvalid;
    logic [NUM_PORTS-1:0] port_err;
    logic [DATA_W-1:0]    port_rdata [NUM_PORTS];

    assign port_fire[PORT_M]     = m_gnt_c;
    assign port_we[PORT_M]       = m_we;
    assign port_in_range[PORT_M] = m_in_range;
    assign port_fire[PORT_D]     = d_gnt_c;
    assign port_we[PORT_D]       = d_we;
    assign port_in_range[PORT_D] = d_in_range;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
        dmem_rsp_reg u_rsp (
            .clk       (clk),
            .rst       (rst),
            .fire      (port_fire[gi]),
            .we        (port_we[gi]),
            .in_range  (port_in_range[gi]),
            .mem_rdata (mem_rdata),
            .rvalid    (port_rvalid[gi]),
            .rdata     (port_rdata[gi]),
            .err       (port_err[gi])
        );
    end

    assign m_rvalid = port_rvalid[PORT_M];
    assign m_rdata  = port_rdata[PORT_M];
    assign d_rvalid = port_rvalid[PORT_D];
    assign d_rdata  = port_rdata[PORT_D];
    // Grants are exclusive, so at most one port can report an error.
    assign err      = |port_err;

endmodule
